// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID->EX pipeline register. Each cycle it captures the register-file read
//   data, the instruction fields and the opaque control bundle. Source operands
//   are forwarded from MEM/WB ahead of the register-file values. A load in EX
//   whose destination is read by the instruction in ID is a load-use hazard:
//   ID is stalled and a bubble goes into EX. A taken branch/jump (flush)
//   squashes the instruction in ID.
//
// Parameters
//   CTRL_W  width of the control bundle carried ID->EX
//   REG_AW  register address width (r0 reads as zero and is never forwarded)
//
// Ports
//   CLK, Reset                  clock; synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_rs, id_rt, id_wAddr      source / destination register addresses
//   id_readData1/2              register-file data for rs / rt
//   id_imm, id_ctrl             immediate and decoded control bundle
//   id_regWrite, id_isLoad      instruction writes id_wAddr / is a load
//   flush                       squash the instruction in ID
//   mem_regWrite/wAddr/wData    MEM-stage writer (ALU result only)
//   wb_regWrite/wAddr/wData     WB-stage writer
//   stall_id                    combinational; hold PC and IF/ID this cycle
//   ex_*                        registered EX-stage fields and forwarded operands
//   stat_bubbles                hazard bubble count (only with ID_EX_STATS_EN)
//
// Build option
//   ID_EX_STATS_EN  adds stat_bubbles: saturating count of hazard bubbles
//                   (flush bubbles not counted), cleared by Reset.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 12,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_wAddr,
    input  logic [31:0]       id_readData1,
    input  logic [31:0]       id_readData2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_regWrite,
    input  logic              id_isLoad,
    input  logic              flush,
    input  logic              mem_regWrite,
    input  logic [REG_AW-1:0] mem_wAddr,
    input  logic [31:0]       mem_wData,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_wAddr,
    input  logic [31:0]       wb_wData,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wAddr,
    output logic [31:0]       ex_opA,
    output logic [31:0]       ex_opB,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_regWrite,
    output logic              ex_isLoad
`ifdef ID_EX_STATS_EN
    ,
    output logic [15:0]       stat_bubbles
`endif
);

    typedef enum logic {
        CAP_NORMAL,
        CAP_BUBBLE
    } capMode_t;

    logic        haz;
    capMode_t    capMode;
    logic [31:0] fwdA;
    logic [31:0] fwdB;

    // Operand select: r0 is always zero, then MEM, then WB, then register file.
    function automatic logic [31:0] fwdSel(
        input logic [REG_AW-1:0] rAddr,
        input logic [31:0]       rfData,
        input logic              memWe,
        input logic [REG_AW-1:0] memAddr,
        input logic [31:0]       memData,
        input logic              wbWe,
        input logic [REG_AW-1:0] wbAddr,
        input logic [31:0]       wbData
    );
        if (rAddr == '0)
            return '0;
        else if (memWe && (memAddr == rAddr))
            return memData;
        else if (wbWe && (wbAddr == rAddr))
            return wbData;
        else
            return rfData;
    endfunction

    // ex_isLoad is already gated by ex_valid, so a bubble can never create a
    // hazard; back-to-back load-use stalls are therefore at most 1 cycle each.
    always_comb begin
        haz = ex_valid && ex_isLoad && (ex_wAddr != '0) && id_valid &&
              ((ex_wAddr == id_rs) || (ex_wAddr == id_rt));
    end

    assign stall_id = haz && !flush && !Reset;

    always_comb begin
        capMode = CAP_NORMAL;
        if (flush || haz)
            capMode = CAP_BUBBLE;
    end

    always_comb begin
        fwdA = fwdSel(id_rs, id_readData1, mem_regWrite, mem_wAddr, mem_wData,
                      wb_regWrite, wb_wAddr, wb_wData);
        fwdB = fwdSel(id_rt, id_readData2, mem_regWrite, mem_wAddr, mem_wData,
                      wb_regWrite, wb_wAddr, wb_wData);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_wAddr    <= '0;
            ex_opA      <= '0;
            ex_opB      <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
            ex_regWrite <= 1'b0;
            ex_isLoad   <= 1'b0;
        end else begin
            case (capMode)
                CAP_BUBBLE: begin
                    ex_valid    <= 1'b0;
                    ex_rs       <= '0;
                    ex_rt       <= '0;
                    ex_wAddr    <= '0;
                    ex_opA      <= '0;
                    ex_opB      <= '0;
                    ex_imm      <= '0;
                    ex_ctrl     <= '0;
                    ex_regWrite <= 1'b0;
                    ex_isLoad   <= 1'b0;
                end
                default: begin
                    ex_valid    <= id_valid;
                    ex_rs       <= id_rs;
                    ex_rt       <= id_rt;
                    ex_wAddr    <= id_wAddr;
                    ex_opA      <= fwdA;
                    ex_opB      <= fwdB;
                    ex_imm      <= id_imm;
                    ex_ctrl     <= id_valid ? id_ctrl : '0;
                    ex_regWrite <= id_valid && id_regWrite;
                    ex_isLoad   <= id_valid && id_isLoad;
                end
            endcase
        end
    end

`ifdef ID_EX_STATS_EN
    logic [15:0] bubbleCnt;

    always_ff @(posedge CLK) begin
        if (Reset)
            bubbleCnt <= '0;
        else if (haz && !flush && (bubbleCnt != '1))
            bubbleCnt <= bubbleCnt + 16'd1;
    end

    assign stat_bubbles = bubbleCnt;
`endif

endmodule
